// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus definitions: instruction-cycle states, drive sources and
// the opcode fields a memory-side responder has to recognise.
package mcs4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_A1   = 4'd1,
        ST_A2   = 4'd2,
        ST_A3   = 4'd3,
        ST_M1   = 4'd4,
        ST_M2   = 4'd5,
        ST_X1   = 4'd6,
        ST_X2   = 4'd7,
        ST_X3   = 4'd8
    } cyc_state_e;

    typedef enum logic [1:0] {
        DRV_OPR = 2'd0,
        DRV_OPA = 2'd1,
        DRV_IO  = 2'd2
    } drv_sel_e;

    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_IO      = 4'hE;
    localparam logic [3:0] OPA_WRR     = 4'h2;
    localparam logic [3:0] OPA_WPM     = 4'h3;
    localparam logic [3:0] OPA_RDR     = 4'hA;
    localparam logic [3:0] PAGE_PORT   = 4'hF;

    // Free-running subcycle sequence; IDLE is left only through SYNC.
    function automatic cyc_state_e cyc_next(input cyc_state_e s);
        case (s)
            ST_IDLE: cyc_next = ST_IDLE;
            ST_A1:   cyc_next = ST_A2;
            ST_A2:   cyc_next = ST_A3;
            ST_A3:   cyc_next = ST_M1;
            ST_M1:   cyc_next = ST_M2;
            ST_M2:   cyc_next = ST_X1;
            ST_X1:   cyc_next = ST_X2;
            ST_X2:   cyc_next = ST_X3;
            ST_X3:   cyc_next = ST_A1;
            default: cyc_next = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/i4289_bus_if_if.sv
// Side-band bundle between an MCS-4 program-memory responder and its
// surroundings: CPU control pins, memory port and I/O port.
interface i4289_bus_if_if;

    logic        clk1_pad;
    logic        clk2_pad;
    logic        sync_pad;
    logic        cmrom_pad;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [3:0]  mem_wdata;
    logic        mem_wr_hi;
    logic        mem_wr_lo;
    logic [3:0]  io_port;
    logic [3:0]  io_wdata;
    logic        io_wr;
    logic [3:0]  io_rdata;
    // High while the responder is driving data_pad.
    logic        data_oe;

    modport slave (
        input  clk1_pad, clk2_pad, sync_pad, cmrom_pad, mem_rdata, io_rdata,
        output mem_addr, mem_rd, mem_wdata, mem_wr_hi, mem_wr_lo,
               io_port, io_wdata, io_wr, data_oe
    );

    modport master (
        output clk1_pad, clk2_pad, sync_pad, cmrom_pad, mem_rdata, io_rdata,
        input  mem_addr, mem_rd, mem_wdata, mem_wr_hi, mem_wr_lo,
               io_port, io_wdata, io_wr, data_oe
    );

endinterface

// File: rtl/mcs4_phase_det.sv
// Turns the two-phase 4004 clocks into single-sysclk events: tick on the
// clk2 falling edge and c1r on the clk1 rising edge.
module mcs4_phase_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk1_i,
    input  logic clk2_i,
    output logic tick_o,
    output logic c1r_o
);

    logic clk1_q;
    logic clk2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk1_q <= 1'b0;
            clk2_q <= 1'b0;
        end else begin
            clk1_q <= clk1_i;
            clk2_q <= clk2_i;
        end
    end

    assign tick_o = clk2_q & ~clk2_i;
    assign c1r_o  = ~clk1_q & clk1_i;

endmodule

// File: rtl/i4289_bus_if.sv
// MCS-4 program-memory responder: serves instruction fetches from byte-wide
// memory and handles SRC, WRR, RDR and WPM on behalf of an i4004.
module i4289_bus_if
    import mcs4_pkg::*;
#(
    parameter logic BANK_SEL = 1'b1
) (
    input  logic           sysclk,
    input  logic           poc_pad,
    inout  wire  [3:0]     data_pad,
    i4289_bus_if_if.slave  bus
);

    logic        tick_s;
    logic        c1r_s;
    cyc_state_e  state_q;
    cyc_state_e  state_d;
    logic [11:0] addr_q;
    logic [11:0] addr_d;
    logic        sel_q;
    logic [7:0]  opbuf_q;
    logic [3:0]  opr_q;
    logic [3:0]  opa_q;
    logic        ioc_q;
    logic [7:0]  src_q;
    logic        src_lo_pend_q;
    logic [3:0]  page_q;
    logic        wpm_toggle_q;
    logic [11:0] mem_addr_q;
    logic        mem_rd_q;
    logic [3:0]  mem_wdata_q;
    logic        mem_wr_hi_q;
    logic        mem_wr_lo_q;
    logic [3:0]  io_wdata_q;
    logic        io_wr_q;
    logic [3:0]  rdr_q;
    logic        oe_q;
    drv_sel_e    drv_sel_q;
    logic [3:0]  dout_s;
    logic        bank_hit_s;
    logic        src_hit_s;
    logic        io_grp_s;

    mcs4_phase_det u_phase (
        .clk_i  (sysclk),
        .rst_i  (poc_pad),
        .clk1_i (bus.clk1_pad),
        .clk2_i (bus.clk2_pad),
        .tick_o (tick_s),
        .c1r_o  (c1r_s)
    );

    assign state_d    = bus.sync_pad ? ST_A1 : cyc_next(state_q);
    assign bank_hit_s = (bus.cmrom_pad == BANK_SEL);
    assign src_hit_s  = (opr_q == OPR_FIM_SRC) && opa_q[0] && bus.cmrom_pad;
    assign io_grp_s   = ioc_q && (opr_q == OPR_IO);

    // Address nibble collected during the current A subcycle.
    always_comb begin
        addr_d = addr_q;
        case (state_q)
            ST_A1:   addr_d[3:0]  = data_pad;
            ST_A2:   addr_d[7:4]  = data_pad;
            ST_A3:   addr_d[11:8] = data_pad;
            default: addr_d = addr_q;
        endcase
    end

    // Cycle FSM, bus decode and all strobes; sampling on tick, driving from c1r.
    always_ff @(posedge sysclk) begin
        if (poc_pad) begin
            state_q       <= ST_IDLE;
            addr_q        <= 12'h000;
            sel_q         <= 1'b0;
            opbuf_q       <= 8'h00;
            opr_q         <= 4'h0;
            opa_q         <= 4'h0;
            ioc_q         <= 1'b0;
            src_q         <= 8'h00;
            src_lo_pend_q <= 1'b0;
            page_q        <= 4'h0;
            wpm_toggle_q  <= 1'b0;
            mem_addr_q    <= 12'h000;
            mem_rd_q      <= 1'b0;
            mem_wdata_q   <= 4'h0;
            mem_wr_hi_q   <= 1'b0;
            mem_wr_lo_q   <= 1'b0;
            io_wdata_q    <= 4'h0;
            io_wr_q       <= 1'b0;
            rdr_q         <= 4'h0;
            oe_q          <= 1'b0;
            drv_sel_q     <= DRV_OPR;
        end else begin
            mem_rd_q    <= 1'b0;
            mem_wr_hi_q <= 1'b0;
            mem_wr_lo_q <= 1'b0;
            io_wr_q     <= 1'b0;
            if (tick_s) begin
                oe_q    <= 1'b0;
                state_q <= state_d;
                addr_q  <= addr_d;
                case (state_q)
                    ST_A3: begin
                        sel_q <= bank_hit_s;
                        if (bank_hit_s) begin
                            mem_addr_q <= addr_d;
                            mem_rd_q   <= 1'b1;
                        end
                    end
                    ST_M1: opr_q <= data_pad;
                    ST_M2: begin
                        opa_q <= data_pad;
                        ioc_q <= bus.cmrom_pad;
                    end
                    ST_X2: begin
                        if (src_hit_s) begin
                            src_q[7:4]    <= data_pad;
                            src_lo_pend_q <= 1'b1;
                            wpm_toggle_q  <= 1'b0;
                        end else if (io_grp_s) begin
                            case (opa_q)
                                OPA_WRR: begin
                                    // Port F is the WPM page register, not a real port.
                                    if (src_q[7:4] == PAGE_PORT) begin
                                        page_q <= data_pad;
                                    end else begin
                                        io_wdata_q <= data_pad;
                                        io_wr_q    <= 1'b1;
                                    end
                                end
                                OPA_WPM: begin
                                    mem_addr_q   <= {page_q, src_q};
                                    mem_wdata_q  <= data_pad;
                                    mem_wr_hi_q  <= ~wpm_toggle_q;
                                    mem_wr_lo_q  <= wpm_toggle_q;
                                    wpm_toggle_q <= ~wpm_toggle_q;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                    ST_X3: begin
                        if (src_lo_pend_q) begin
                            src_q[3:0] <= data_pad;
                        end
                        src_lo_pend_q <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end else if (c1r_s) begin
                case (state_q)
                    ST_M1: begin
                        if (sel_q) begin
                            opbuf_q   <= bus.mem_rdata;
                            drv_sel_q <= DRV_OPR;
                            oe_q      <= 1'b1;
                        end
                    end
                    ST_M2: begin
                        if (sel_q) begin
                            drv_sel_q <= DRV_OPA;
                            oe_q      <= 1'b1;
                        end
                    end
                    ST_X2: begin
                        if (io_grp_s && (opa_q == OPA_RDR)) begin
                            rdr_q     <= bus.io_rdata;
                            drv_sel_q <= DRV_IO;
                            oe_q      <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            // A resync always wins over any drive in progress.
            if (bus.sync_pad) begin
                oe_q <= 1'b0;
            end
        end
    end

    // Source of the nibble presented on data_pad.
    always_comb begin
        case (drv_sel_q)
            DRV_OPR: dout_s = opbuf_q[7:4];
            DRV_OPA: dout_s = opbuf_q[3:0];
            DRV_IO:  dout_s = rdr_q;
            default: dout_s = 4'h0;
        endcase
    end

    assign data_pad       = oe_q ? dout_s : 4'bzzzz;
    assign bus.data_oe    = oe_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wr_hi  = mem_wr_hi_q;
    assign bus.mem_wr_lo  = mem_wr_lo_q;
    assign bus.io_port    = src_q[7:4];
    assign bus.io_wdata   = io_wdata_q;
    assign bus.io_wr      = io_wr_q;

endmodule
